// File: rtl/arbitro_estacionamiento.sv
// Parking-lot barrier arbiter: grants one lane at a time, tracks occupancy, refuses entry when full.
// Build option: define ARBITRO_PRIORIDAD_SALIDA_EN to always favour the exit lane on simultaneous requests.
module arbitro_estacionamiento #(
  parameter int CAPACIDAD  = 7,
  parameter int ANCHO      = 3,
  parameter int T_APERTURA = 24000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_ent,
  input  logic             req_sal,
  input  logic             paso_ent,
  input  logic             paso_sal,
  output logic             barrera_ent,
  output logic             barrera_sal,
  output logic [ANCHO-1:0] ocupacion,
  output logic             lleno,
  output logic             vacio,
  output logic             rechazo
);

  localparam int TW = (T_APERTURA > 1) ? $clog2(T_APERTURA) : 1;
  localparam logic [TW-1:0]    T_FIN = TW'(T_APERTURA - 1);
  localparam logic [ANCHO-1:0] CAP   = ANCHO'(CAPACIDAD);

  localparam logic [1:0] IDLE        = 2'b00;
  localparam logic [1:0] ABIERTA_ENT = 2'b01;
  localparam logic [1:0] ABIERTA_SAL = 2'b10;
  localparam logic [1:0] CIERRE      = 2'b11;

  logic [1:0]    estado, estado_sig;
  logic [TW-1:0] timer;
  logic          armado;
  logic          eleg_ent, eleg_sal;
  logic          grant_ent, grant_sal;
  logic          rechazar, fin_ventana;

  function automatic logic [ANCHO-1:0] sat_inc(input logic [ANCHO-1:0] v);
    return (v >= CAP) ? v : v + ANCHO'(1);
  endfunction

  function automatic logic [ANCHO-1:0] sat_dec(input logic [ANCHO-1:0] v);
    return (v == '0) ? v : v - ANCHO'(1);
  endfunction

`ifndef ARBITRO_PRIORIDAD_SALIDA_EN
  // Round-robin pointer: set means the next tie goes to the exit lane.
  logic prox_sal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prox_sal <= 1'b0;
    end else if (grant_ent) begin
      prox_sal <= 1'b1;
    end else if (grant_sal) begin
      prox_sal <= 1'b0;
    end
  end
`endif

  always_comb begin
    eleg_ent  = req_ent & ~lleno;
    eleg_sal  = req_sal & ~vacio;
    grant_ent = 1'b0;
    grant_sal = 1'b0;
    if (estado == IDLE) begin
`ifdef ARBITRO_PRIORIDAD_SALIDA_EN
      grant_sal = eleg_sal;
      grant_ent = eleg_ent & ~eleg_sal;
`else
      if (eleg_ent && eleg_sal) begin
        grant_sal = prox_sal;
        grant_ent = ~prox_sal;
      end else begin
        grant_ent = eleg_ent;
        grant_sal = eleg_sal;
      end
`endif
    end
    rechazar    = (estado == IDLE) & req_ent & lleno & ~grant_sal & armado;
    fin_ventana = (timer == T_FIN);
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE: begin
        if (grant_ent)      estado_sig = ABIERTA_ENT;
        else if (grant_sal) estado_sig = ABIERTA_SAL;
      end
      ABIERTA_ENT: if (paso_ent || fin_ventana) estado_sig = CIERRE;
      ABIERTA_SAL: if (paso_sal || fin_ventana) estado_sig = CIERRE;
      default:     estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= IDLE;
      timer     <= '0;
      ocupacion <= '0;
      rechazo   <= 1'b0;
      armado    <= 1'b1;
    end else begin
      estado  <= estado_sig;
      rechazo <= rechazar;
      // The window timer runs only while a barrier is open and restarts from zero on each grant.
      if (estado == ABIERTA_ENT || estado == ABIERTA_SAL) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end
      if (estado == ABIERTA_ENT && paso_ent) begin
        ocupacion <= sat_inc(ocupacion);
      end else if (estado == ABIERTA_SAL && paso_sal) begin
        ocupacion <= sat_dec(ocupacion);
      end
      // A refusal re-arms only once the entry request has dropped.
      if (!req_ent) begin
        armado <= 1'b1;
      end else if (rechazar) begin
        armado <= 1'b0;
      end
    end
  end

  assign barrera_ent = (estado == ABIERTA_ENT);
  assign barrera_sal = (estado == ABIERTA_SAL);
  assign lleno       = (ocupacion == CAP);
  assign vacio       = (ocupacion == '0);

endmodule

// File: tb/tb_arbitro_estacionamiento.sv
// Scoreboard bench for arbitro_estacionamiento (T_APERTURA=10, CAPACIDAD=7).
module tb_arbitro_estacionamiento;
  localparam int CAP = 7;
  localparam int AN  = 3;
  localparam int TA  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_ent = 1'b0, req_sal = 1'b0, paso_ent = 1'b0, paso_sal = 1'b0;
  logic barrera_ent, barrera_sal, lleno, vacio, rechazo;
  logic [AN-1:0] ocupacion;

  int total = 0;
  int bad   = 0;
  int fin_occ;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } item_t;
  item_t sb[$];

  always #5 clk = ~clk;

  arbitro_estacionamiento #(
    .CAPACIDAD (CAP),
    .ANCHO     (AN),
    .T_APERTURA(TA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_ent    (req_ent),
    .req_sal    (req_sal),
    .paso_ent   (paso_ent),
    .paso_sal   (paso_sal),
    .barrera_ent(barrera_ent),
    .barrera_sal(barrera_sal),
    .ocupacion  (ocupacion),
    .lleno      (lleno),
    .vacio      (vacio),
    .rechazo    (rechazo)
  );

  task automatic chequear(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (occ,lleno,vacio,b_ent,b_sal,rechazo)", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] esp(input int occ, input logic be, input logic bs, input logic rz);
    logic [2:0] o;
    o = 3'(occ);
    return {o, (occ == CAP), (occ == 0), be, bs, rz};
  endfunction

  task automatic empujar(input string tag, input int occ, input logic be, input logic bs, input logic rz);
    item_t it;
    it.tag = tag;
    it.exp = esp(occ, be, bs, rz);
    sb.push_back(it);
  endtask

  task automatic comparar();
    item_t it;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got none want item");
    end else begin
      it = sb.pop_front();
      chequear(it.tag, {ocupacion, lleno, vacio, barrera_ent, barrera_sal, rechazo}, it.exp);
    end
  endtask

  task automatic ciclo(input string tag, input int occ, input logic be, input logic bs, input logic rz);
    empujar(tag, occ, be, bs, rz);
    @(posedge clk);
    @(negedge clk);
    comparar();
  endtask

  task automatic pase_ent(input int occ);
    req_ent = 1'b1;
    ciclo("ent_abre", occ, 1'b1, 1'b0, 1'b0);
    req_ent = 1'b0;
    paso_ent = 1'b1;
    ciclo("ent_cierre", occ + 1, 1'b0, 1'b0, 1'b0);
    paso_ent = 1'b0;
    ciclo("ent_idle", occ + 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pase_sal(input int occ);
    req_sal = 1'b1;
    ciclo("sal_abre", occ, 1'b0, 1'b1, 1'b0);
    req_sal = 1'b0;
    paso_sal = 1'b1;
    ciclo("sal_cierre", occ - 1, 1'b0, 1'b0, 1'b0);
    paso_sal = 1'b0;
    ciclo("sal_idle", occ - 1, 1'b0, 1'b0, 1'b0);
  endtask

  // Both requests are held by the caller; one grant-pass-close round.
  task automatic ronda(input logic sal, input int occ);
    int nxt;
    nxt = sal ? occ - 1 : occ + 1;
    ciclo("rr_abre", occ, ~sal, sal, 1'b0);
    paso_ent = ~sal;
    paso_sal = sal;
    ciclo("rr_cierre", nxt, 1'b0, 1'b0, 1'b0);
    paso_ent = 1'b0;
    paso_sal = 1'b0;
    ciclo("rr_idle", nxt, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    ciclo("reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Empty lot: exit request and stray pulses must do nothing.
    req_sal = 1'b1;
    paso_sal = 1'b1;
    ciclo("vacio_sal", 0, 1'b0, 1'b0, 1'b0);
    paso_sal = 1'b0;
    paso_ent = 1'b1;
    ciclo("paso_suelto", 0, 1'b0, 1'b0, 1'b0);
    paso_ent = 1'b0;
    ciclo("vacio_sal2", 0, 1'b0, 1'b0, 1'b0);
    req_sal = 1'b0;

    // Entry with pass on cycle 4.
    req_ent = 1'b1;
    ciclo("a_c1", 0, 1'b1, 1'b0, 1'b0);
    req_ent = 1'b0;
    ciclo("a_c2", 0, 1'b1, 1'b0, 1'b0);
    ciclo("a_c3", 0, 1'b1, 1'b0, 1'b0);
    ciclo("a_c4", 0, 1'b1, 1'b0, 1'b0);
    paso_ent = 1'b1;
    ciclo("a_cierre", 1, 1'b0, 1'b0, 1'b0);
    paso_ent = 1'b0;
    ciclo("a_idle", 1, 1'b0, 1'b0, 1'b0);

    // Entry window timing out.
    req_ent = 1'b1;
    ciclo("to_abre", 1, 1'b1, 1'b0, 1'b0);
    req_ent = 1'b0;
    for (int i = 1; i < TA; i++) ciclo("to_abierta", 1, 1'b1, 1'b0, 1'b0);
    ciclo("to_cierre", 1, 1'b0, 1'b0, 1'b0);
    ciclo("to_idle", 1, 1'b0, 1'b0, 1'b0);

    for (int o = 1; o < CAP; o++) pase_ent(o);

    // Full lot: single refusal pulse, re-armed by request drop.
    req_ent = 1'b1;
    ciclo("lleno_rz", CAP, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) ciclo("lleno_sin", CAP, 1'b0, 1'b0, 1'b0);
    req_ent = 1'b0;
    ciclo("lleno_baja", CAP, 1'b0, 1'b0, 1'b0);
    req_ent = 1'b1;
    ciclo("lleno_rz2", CAP, 1'b0, 1'b0, 1'b1);
    req_ent = 1'b0;
    ciclo("lleno_fin", CAP, 1'b0, 1'b0, 1'b0);

    // Exit with a mismatched entry pulse first.
    req_sal = 1'b1;
    ciclo("sx_abre", 7, 1'b0, 1'b1, 1'b0);
    req_sal = 1'b0;
    paso_ent = 1'b1;
    ciclo("sx_paso_ent", 7, 1'b0, 1'b1, 1'b0);
    paso_ent = 1'b0;
    paso_sal = 1'b1;
    ciclo("sx_cierre", 6, 1'b0, 1'b0, 1'b0);
    paso_sal = 1'b0;
    ciclo("sx_idle", 6, 1'b0, 1'b0, 1'b0);
    for (int o = 6; o > 3; o--) pase_sal(o);

    // Simultaneous requests at occupancy 3, last grant was exit.
    req_ent = 1'b1;
    req_sal = 1'b1;
`ifdef ARBITRO_PRIORIDAD_SALIDA_EN
    ronda(1'b1, 3);
    ronda(1'b0, 2);
    ronda(1'b1, 3);
    fin_occ = 2;
`else
    ronda(1'b0, 3);
    ronda(1'b1, 4);
    ronda(1'b0, 3);
    fin_occ = 4;
`endif
    req_ent = 1'b0;
    req_sal = 1'b0;
    ciclo("rr_fin", fin_occ, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an entry window.
    req_ent = 1'b1;
    ciclo("rst_c1", fin_occ, 1'b1, 1'b0, 1'b0);
    req_ent = 1'b0;
    ciclo("rst_c2", fin_occ, 1'b1, 1'b0, 1'b0);
    ciclo("rst_c3", fin_occ, 1'b1, 1'b0, 1'b0);
    empujar("rst_async", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    comparar();
    ciclo("rst_alto", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    pase_ent(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arbitro_estacionamiento.md
ARBITRO_ESTACIONAMIENTO -- requirements
Module: arbitro_estacionamiento

Interface
REQ-001 SHALL have parameter CAPACIDAD, default 7, maximum cars admitted (1..2^ANCHO-1).
REQ-002 SHALL have parameter ANCHO, default 3, width of the occupancy count.
REQ-003 SHALL have parameter T_APERTURA, default 24000000, barrier-open window in clk cycles (2 s at 12 MHz).
REQ-004 SHALL provide clk  input  1  system clock, 12 MHz; one clock; all state on rising edge.
REQ-005 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide req_ent  input  1  entry-lane request level (car waiting at entry sensor), debounced.
REQ-007 SHALL provide req_sal  input  1  exit-lane request level, debounced.
REQ-008 SHALL provide paso_ent  input  1  one-cycle pulse: car completed entry sequence (a then b).
REQ-009 SHALL provide paso_sal  input  1  one-cycle pulse: car completed exit sequence (b then a).
REQ-010 SHALL provide barrera_ent  output  1  entry barrier open command.
REQ-011 SHALL provide barrera_sal  output  1  exit barrier open command.
REQ-012 SHALL provide ocupacion  output  ANCHO  current car count.
REQ-013 SHALL provide lleno  output  1  high when ocupacion == CAPACIDAD.
REQ-014 SHALL provide vacio  output  1  high when ocupacion == 0.
REQ-015 SHALL provide rechazo  output  1  one-cycle pulse when an entry request is refused because lleno.

Function
REQ-016 SHALL implement FSM states IDLE, ABIERTA_ENT, ABIERTA_SAL, CIERRE; exactly one barrier open at a time.
REQ-017 In IDLE, eligible entry = req_ent & ~lleno; eligible exit = req_sal & ~vacio.
REQ-018 Single eligible request SHALL move IDLE -> ABIERTA_x; barrera_x high the cycle after the request is sampled (latency 1).
REQ-019 Both eligible in the same cycle: round-robin, granting the lane not granted last (after reset, entry goes first).
REQ-020 req_ent & lleno in IDLE with no grant SHALL pulse rechazo for 1 cycle, then re-pulse only after req_ent deasserts and reasserts.
REQ-021 In ABIERTA_ENT, paso_ent SHALL increment ocupacion by 1 and move to CIERRE; in ABIERTA_SAL, paso_sal SHALL decrement by 1 and move to CIERRE.
REQ-022 Open window timer SHALL count from 0 on entry to ABIERTA_x; reaching T_APERTURA-1 without paso SHALL move to CIERRE, count unchanged.
REQ-023 CIERRE SHALL last exactly 1 cycle with both barriers low, then return to IDLE.
REQ-024 paso_ent/paso_sal outside its matching ABIERTA state SHALL be ignored.
REQ-025 Count SHALL never exceed CAPACIDAD nor go below 0 (saturating, no wrap-around).
REQ-026 lleno, vacio SHALL be combinational decodes of ocupacion.

Reset
REQ-027 rst high SHALL immediately force: state IDLE, barrera_ent=0, barrera_sal=0, ocupacion=0, rechazo=0, timer=0, round-robin pointer=entry.
REQ-028 rst asserted mid-window SHALL abort the grant without count change; operation resumes on first clk edge after release.

Configuration
REQ-029 Macro ARBITRO_PRIORIDAD_SALIDA_EN defined: simultaneous eligible requests SHALL always grant exit (frees space first).
REQ-030 Macro ARBITRO_PRIORIDAD_SALIDA_EN undefined: round-robin per REQ-019.

Verification (T_APERTURA=10, CAPACIDAD=7, macro undefined unless stated)
REQ-031 Reset, req_ent=1 for 1 cycle, paso_ent at cycle 4 -> barrera_ent high cycles 1..4, CIERRE cycle 5, ocupacion=1, vacio=0.
REQ-032 ocupacion=7, req_ent=1 -> barrera_ent stays 0, lleno=1, rechazo single pulse, ocupacion stays 7.
REQ-033 ocupacion=3, req_ent=req_sal=1 held, passes each grant -> grants alternate ent, sal, ent; final ocupacion=4; with macro defined -> sal, ent, sal; final ocupacion=2.
REQ-034 Grant entry, no paso_ent -> barrera_ent high exactly 10 cycles, then CIERRE 1 cycle, ocupacion unchanged.
REQ-035 ocupacion=0, req_sal=1 and stray paso_sal -> no grant, ocupacion stays 0, vacio=1.
REQ-036 rst asserted at cycle 3 of entry window -> barrera_ent low asynchronously, ocupacion=0, next req_ent granted normally.
